// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage. Owns the architectural PC, issues one instruction
// memory read at a time, buffers returned words in a small FIFO and presents
// {pc, instr, fault} to decode. A redirect flushes the FIFO and causes any
// response still in flight to be dropped.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   pc                current PC, sent to the next-PC generator
//   fetch_stall       tells the generator to hold the PC
//   pc_next           next PC from the generator (pc when stalled, target on redirect)
//   redirect          jump/CSR redirect; flushes fetch state this cycle
//   imem_req_*        read request (valid/ready, address = pc)
//   imem_resp_*       read response (always accepted), data word and fault flag
//   dec_*             FIFO head towards decode (valid/ready, pc, instr, fault)
// ---------------------------------------------------------------------------
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_8000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] pc,
   output logic        fetch_stall,
   input  logic [31:0] pc_next,
   input  logic        redirect,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr,
   output logic        dec_fault
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Fetch FSM states
   localparam logic [1:0] ST_REQ  = 2'd0;   // ready to issue a request
   localparam logic [1:0] ST_WAIT = 2'd1;   // request in flight, response wanted
   localparam logic [1:0] ST_DROP = 2'd2;   // request in flight, response stale

   logic [31:0]      r_pc;
   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [31:0]      r_req_pc;

   logic [31:0]      r_fifo_pc    [DEPTH];
   logic [31:0]      r_fifo_instr [DEPTH];
   logic             r_fifo_fault [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_req_valid;
   logic             w_accept;
   logic             w_enq;
   logic             w_deq;
   logic             w_dec_valid;

   // Only issue when the FIFO is guaranteed to have room for the answer;
   // with a single request in flight this makes overflow impossible.
   assign w_req_valid = (r_state == ST_REQ) && (r_count < CNT_W'(DEPTH))
                        && !redirect && !rst;
   assign w_accept    = w_req_valid && imem_req_ready;

   // A response is only useful while waiting and no redirect kills it.
   // Responses seen in REQ are a memory protocol error and are ignored.
   assign w_enq       = (r_state == ST_WAIT) && imem_resp_valid && !redirect && !rst;
   assign w_dec_valid = (r_count != '0);
   assign w_deq       = w_dec_valid && dec_ready && !redirect;

   // PC advances on accept (generator adds 4), jumps on redirect, else holds.
   assign fetch_stall    = !w_accept && !redirect;
   assign pc             = r_pc;
   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_pc;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_REQ: begin
            if (w_accept) begin
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // A redirect makes the outstanding fetch stale. If its response
            // lands in the same cycle it is simply discarded, otherwise we
            // must still swallow it later.
            if (redirect) begin
               w_state_next = imem_resp_valid ? ST_REQ : ST_DROP;
            end else if (imem_resp_valid) begin
               w_state_next = ST_REQ;
            end
         end
         ST_DROP: begin
            if (imem_resp_valid) begin
               w_state_next = ST_REQ;
            end
         end
         default: w_state_next = ST_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_state  <= ST_REQ;
         r_req_pc <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_pc    <= pc_next;
         r_state <= w_state_next;
         if (w_accept) begin
            r_req_pc <= r_pc;
         end
         // Redirect wins over any same-cycle enqueue or dequeue.
         if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_enq) begin
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_enq && !w_deq) begin
               r_count <= r_count + CNT_W'(1);
            end else if (w_deq && !w_enq) begin
               r_count <= r_count - CNT_W'(1);
            end
         end
      end
   end

   // Storage needs no reset: outputs are masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_fifo_pc[r_wr_ptr]    <= r_req_pc;
         r_fifo_instr[r_wr_ptr] <= imem_resp_data;
         r_fifo_fault[r_wr_ptr] <= imem_resp_err;
      end
   end

   assign dec_valid = w_dec_valid;
   assign dec_pc    = w_dec_valid ? r_fifo_pc[r_rd_ptr]    : 32'd0;
   assign dec_instr = w_dec_valid ? r_fifo_instr[r_rd_ptr] : 32'd0;
   assign dec_fault = w_dec_valid ? r_fifo_fault[r_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//
// Randomised bench for ifetch_unit. The reference model works at transaction
// level: a model PC, an epoch number bumped on every redirect/reset, and a
// queue of expected decode entries. A response is expected at decode only if
// it belongs to the current epoch and no redirect/reset hits in its arrival
// cycle. A separate monitor pops the queue whenever decode consumes an entry.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_8000;
   localparam logic [31:0] XOR_MASK = 32'hFFFF_0000;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        fetch_stall;
   logic [31:0] pc_next;
   logic        redirect;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        imem_resp_err;
   logic        dec_valid;
   logic        dec_ready;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic        dec_fault;
   logic [31:0] tgt;

   typedef struct {
      logic [31:0] addr;   // address the DUT actually requested
      logic [31:0] mpc;    // address the model expected
      logic        err;
      int          due;
      int          ep;
   } mem_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   mem_t        mem_q[$];
   exp_t        exp_q[$];
   exp_t        pop_log[$];
   mem_t        cur;
   logic        cur_on = 1'b0;
   exp_t        mon_e;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          n_acc  = 0;
   int          epoch  = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic        pc_known = 1'b0;

   logic        rst_cmd   = 1'b1;
   logic        redir_cmd = 1'b0;
   logic [31:0] tgt_cmd   = 32'd0;
   int          rdy_pct   = 100;
   int          dec_pct   = 100;
   int          redir_pct = 0;
   int          err_pct   = 0;
   int          lat_min   = 1;
   int          lat_max   = 1;

   // Next-PC generator: hold when stalled, +4 otherwise, target on redirect.
   assign pc_next = redirect ? tgt : (fetch_stall ? pc : pc + 32'd4);

   ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .fetch_stall     (fetch_stall),
      .pc_next         (pc_next),
      .redirect        (redirect),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .imem_resp_err   (imem_resp_err),
      .dec_valid       (dec_valid),
      .dec_ready       (dec_ready),
      .dec_pc          (dec_pc),
      .dec_instr       (dec_instr),
      .dec_fault       (dec_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive all inputs for the new cycle (called 1 time unit after posedge).
   task automatic drive();
      rst = rst_cmd;
      if (redir_cmd) begin
         redirect = 1'b1;
         tgt      = tgt_cmd;
      end else if (int'($urandom_range(0, 99)) < redir_pct) begin
         redirect = 1'b1;
         tgt      = {14'd0, 16'($urandom()), 2'b00};
      end else begin
         redirect = 1'b0;
         tgt      = $urandom();
      end
      cur_on = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         cur    = mem_q.pop_front();
         cur_on = 1'b1;
      end
      // Memory holds one request at a time.
      imem_req_ready  = (mem_q.size() == 0) && (int'($urandom_range(0, 99)) < rdy_pct);
      dec_ready       = int'($urandom_range(0, 99)) < dec_pct;
      imem_resp_valid = cur_on;
      imem_resp_data  = cur_on ? (cur.addr ^ XOR_MASK) : $urandom();
      imem_resp_err   = cur_on ? cur.err : 1'b0;
   endtask

   // Observe the settled cycle and advance the reference model to the edge.
   task automatic sample();
      logic acc;
      acc = imem_req_valid && imem_req_ready;
      if (pc_known) chk("PC", pc, exp_pc);
      if (acc) begin
         n_acc++;
         chk("REQ_ADDR", imem_req_addr, exp_pc);
         mem_q.push_back('{addr: imem_req_addr, mpc: exp_pc,
                           err: (int'($urandom_range(0, 99)) < err_pct),
                           due: cyc + int'($urandom_range(lat_min, lat_max)),
                           ep: epoch});
      end
      if (cur_on && cur.ep == epoch && !redirect && !rst)
         exp_q.push_back('{pc: cur.mpc, instr: cur.mpc ^ XOR_MASK, fault: cur.err});
      if (rst) begin
         epoch++;
         exp_q.delete();
         exp_pc   = RESET_PC;
         pc_known = 1'b1;
      end else if (redirect) begin
         epoch++;
         exp_q.delete();
         exp_pc = tgt;
      end else if (acc) begin
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   task automatic neg();
      @(negedge clk);
      sample();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   task automatic step();
      neg();
      pos();
   endtask

   task automatic do_reset();
      rst_cmd = 1'b1;
      step();
      rst_cmd = 1'b0;
      step();
   endtask

   task automatic wait_acc(input int n);
      int start;
      start = n_acc;
      for (int i = 0; i < 100 && (n_acc - start) < n; i++) step();
      chk("ACC_WAIT", 32'(n_acc - start), 32'(n));
   endtask

   // Scoreboard monitor: compare every consumed decode entry.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && !redirect && dec_valid && dec_ready) begin
            pop_log.push_back('{pc: dec_pc, instr: dec_instr, fault: dec_fault});
            $display("dec pc=%08h instr=%08h fault=%0d", dec_pc, dec_instr, dec_fault);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL DEC_UNEXPECTED: got pc %08h expected no entry (cycle %0d)", dec_pc, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("DEC_PC", dec_pc, mon_e.pc);
               chk("DEC_INSTR", dec_instr, mon_e.instr);
               chk("DEC_FAULT", 32'(dec_fault), 32'(mon_e.fault));
            end
         end
      end
   end

   initial begin
      drive();
      // Reset state
      neg();
      chk("RST_REQV", 32'(imem_req_valid), 32'd0);
      chk("RST_DECV", 32'(dec_valid), 32'd0);
      chk("RST_DECPC", dec_pc, 32'd0);
      chk("RST_DECINSTR", dec_instr, 32'd0);
      chk("RST_DECFAULT", 32'(dec_fault), 32'd0);
      chk("RST_PC", pc, RESET_PC);
      rst_cmd = 1'b0;
      pos();

      // Free run: one instruction per two cycles
      pop_log.delete();
      repeat (20) step();
      chk("RUN_RATE", 32'(pop_log.size() >= 9 && pop_log.size() <= 10), 32'd1);
      if (pop_log.size() >= 3) begin
         chk("RUN_PC0", pop_log[0].pc, 32'h8000);
         chk("RUN_PC2", pop_log[2].pc, 32'h8008);
         chk("RUN_INSTR1", pop_log[1].instr, 32'h8004 ^ XOR_MASK);
      end

      // Backpressure: FIFO fills after two requests
      dec_pct = 0;
      do_reset();
      begin
         int a0;
         a0 = n_acc;
         repeat (12) step();
         neg();
         chk("BP_NACC", 32'(n_acc - a0), 32'd2);
         chk("BP_REQV", 32'(imem_req_valid), 32'd0);
         chk("BP_STALL", 32'(fetch_stall), 32'd1);
         chk("BP_PC", pc, 32'h8008);
         pos();
      end
      pop_log.delete();
      dec_pct = 100;
      repeat (12) step();
      chk("BP_POPS", 32'(pop_log.size() >= 3), 32'd1);
      if (pop_log.size() >= 3) begin
         chk("BP_ORDER0", pop_log[0].pc, 32'h8000);
         chk("BP_ORDER1", pop_log[1].pc, 32'h8004);
         chk("BP_ORDER2", pop_log[2].pc, 32'h8008);
      end

      // Redirect while a response is still three cycles away
      dec_pct = 0;
      lat_min = 5;
      lat_max = 5;
      do_reset();
      wait_acc(2);
      redir_cmd = 1'b1;
      tgt_cmd   = 32'h9000;
      step();
      redir_cmd = 1'b0;
      step();
      neg();
      chk("RW_FLUSH", 32'(dec_valid), 32'd0);
      chk("RW_DROP_NOREQ", 32'(imem_req_valid), 32'd0);
      pos();
      pop_log.delete();
      dec_pct = 100;
      repeat (15) step();
      chk("RW_POPS", 32'(pop_log.size() >= 1), 32'd1);
      if (pop_log.size() >= 1) chk("RW_FIRST_PC", pop_log[0].pc, 32'h9000);

      // Redirect in the same cycle as the response
      lat_min = 2;
      lat_max = 2;
      wait_acc(1);
      redir_cmd = 1'b1;
      tgt_cmd   = 32'hA000;
      step();
      redir_cmd = 1'b0;
      step();
      pop_log.delete();
      neg();
      chk("RC_REQV", 32'(imem_req_valid), 32'd1);
      chk("RC_ADDR", imem_req_addr, 32'hA000);
      pos();
      repeat (10) step();
      chk("RC_POPS", 32'(pop_log.size() >= 1), 32'd1);
      if (pop_log.size() >= 1) chk("RC_FIRST_PC", pop_log[0].pc, 32'hA000);

      // Memory stall then faulting response
      rdy_pct = 0;
      err_pct = 100;
      lat_min = 1;
      lat_max = 1;
      repeat (6) step();
      pop_log.delete();
      begin
         logic [31:0] a_hold;
         a_hold = exp_pc;
         for (int i = 0; i < 5; i++) begin
            neg();
            chk("MS_REQV", 32'(imem_req_valid), 32'd1);
            chk("MS_ADDR", imem_req_addr, a_hold);
            chk("MS_STALL", 32'(fetch_stall), 32'd1);
            if (i == 4) rdy_pct = 100;
            pos();
         end
         repeat (6) step();
         chk("MS_POPS", 32'(pop_log.size() >= 1), 32'd1);
         if (pop_log.size() >= 1) begin
            chk("MS_PC", pop_log[0].pc, a_hold);
            chk("MS_FAULT", 32'(pop_log[0].fault), 32'd1);
         end
      end
      err_pct = 0;

      // Reset while a request is outstanding
      lat_min = 4;
      lat_max = 4;
      wait_acc(1);
      do_reset();
      pop_log.delete();
      neg();
      chk("RM_PC", pc, RESET_PC);
      chk("RM_DECV", 32'(dec_valid), 32'd0);
      chk("RM_REQV", 32'(imem_req_valid), 32'd1);
      pos();
      repeat (12) step();
      chk("RM_POPS", 32'(pop_log.size() >= 1), 32'd1);
      if (pop_log.size() >= 1) begin
         chk("RM_FIRST_PC", pop_log[0].pc, RESET_PC);
         chk("RM_FIRST_INSTR", pop_log[0].instr, RESET_PC ^ XOR_MASK);
      end

      // Random traffic
      lat_min   = 1;
      lat_max   = 4;
      rdy_pct   = 70;
      dec_pct   = 60;
      redir_pct = 4;
      err_pct   = 25;
      repeat (2000) step();

      // Drain: stop fetching and let everything in flight reach decode
      redir_pct = 0;
      rdy_pct   = 0;
      dec_pct   = 100;
      repeat (20) step();
      neg();
      chk("DRAIN_Q", 32'(exp_q.size()), 32'd0);
      chk("DRAIN_DECV", 32'(dec_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
